// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_e;

  // Signed variants take absolute values of operands and fix up result signs.
  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_adj.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_sign_adj #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout_c
);

  assign dout_c = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, plus single-cycle MTHI/MTLO.
// Optional build macro: MULDIV_DIV0_FLAG_EN (divide-by-zero suppresses write, pulses div0).
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       MULDIV_OP,
  input  logic             start,
  input  logic [WIDTH-1:0] A_data,
  input  logic [WIDTH-1:0] B_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI_data,
  output logic [WIDTH-1:0] LO_data
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opa_q, opb_q, upper_q, lower_q;
  logic             neg_q, sa_q, div_q;
  logic             idle, is_mul, is_div, sgn, sa, sb, go, wr_res;
  logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign op     = muldiv_op_e'(MULDIV_OP);
  assign idle   = (state_q == ST_IDLE);
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn    = op_is_signed(op);
  assign sa     = sgn & A_data[WIDTH-1];
  assign sb     = sgn & B_data[WIDTH-1];
  assign go     = idle & start & (is_mul | is_div);

  muldiv_sign_adj #(.W(WIDTH)) u_abs_a (.neg(sa), .din(A_data), .dout_c(abs_a));
  muldiv_sign_adj #(.W(WIDTH)) u_abs_b (.neg(sb), .din(B_data), .dout_c(abs_b));
  muldiv_sign_adj #(.W(W2))    u_fix_p (.neg(neg_q), .din({upper_q, lower_q}), .dout_c(prod_fix));
  muldiv_sign_adj #(.W(WIDTH)) u_fix_q (.neg(neg_q), .din(lower_q), .dout_c(quo_fix));
  muldiv_sign_adj #(.W(WIDTH)) u_fix_r (.neg(sa_q),  .din(upper_q), .dout_c(rem_fix));

  // One shift-add step (multiplier bits consumed from lower_q LSB) and one restoring step.
  assign mul_sum   = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opa_q} : '0);
  assign div_shift = {upper_q, lower_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_diff  = WIDTH'(div_shift - {1'b0, opb_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = is_mul ? ST_MUL : ST_DIV;
      ST_MUL,
      ST_DIV:  if (cnt_q == LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MULDIV_DIV0_FLAG_EN
  logic bzero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  bzero_q <= 1'b0;
    else if (go) bzero_q <= is_div && (B_data == '0);
  end
  assign wr_res = (state_q == ST_FIX) && !(div_q && bzero_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div0 <= 1'b0;
    else        div0 <= (state_q == ST_FIX) && div_q && bzero_q;
  end
`else
  assign wr_res = (state_q == ST_FIX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      upper_q <= '0;
      lower_q <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (go) begin
          opa_q   <= abs_a;
          opb_q   <= abs_b;
          upper_q <= '0;
          lower_q <= is_mul ? abs_b : abs_a;
          cnt_q   <= '0;
          neg_q   <= sa ^ sb;
          sa_q    <= sa;
          div_q   <= is_div;
        end
        ST_MUL: begin
          upper_q <= mul_sum[WIDTH:1];
          lower_q <= {mul_sum[0], lower_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + CW'(1);
        end
        ST_DIV: begin
          upper_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          lower_q <= {lower_q[WIDTH-2:0], div_ge};
          cnt_q   <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO change only on MTHI/MTLO accept edges and the FIX edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HI_data <= '0;
      LO_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) busy <= 1'b1;
      if (idle && start && (op == OP_MTHI)) HI_data <= A_data;
      if (idle && start && (op == OP_MTLO)) LO_data <= A_data;
      if (state_q == ST_FIX) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (wr_res) begin
        HI_data <= div_q ? rem_fix : prod_fix[W2-1:WIDTH];
        LO_data <= div_q ? quo_fix : prod_fix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: random and directed ops against an arithmetic reference.
module tb_muldiv_hilo_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   MULDIV_OP;
  logic         start;
  logic [W-1:0] A_data, B_data;
  logic         busy, done;
  logic [W-1:0] HI_data, LO_data;
`ifdef MULDIV_DIV0_FLAG_EN
  logic         div0;
`endif

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .MULDIV_OP(MULDIV_OP), .start(start),
    .A_data(A_data), .B_data(B_data), .busy(busy), .done(done),
    .HI_data(HI_data), .LO_data(LO_data)
`ifdef MULDIV_DIV0_FLAG_EN
    , .div0(div0)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: plain 64-bit arithmetic, division truncates toward zero, remainder follows dividend.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sbv;
    logic [63:0] p;
    e.hi = '0; e.lo = '0; e.dz = 1'b0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd3: begin
        if (b == '0) begin
          e.dz = 1'b1;
          e.lo = a[W-1] ? 32'd1 : 32'hFFFF_FFFF;
          e.hi = a;
        end else begin
          e.lo = W'(sa / sbv);
          e.hi = W'(sa % sbv);
        end
      end
      3'd4: begin
        if (b == '0) begin
          e.dz = 1'b1;
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    MULDIV_OP = op; A_data = a; B_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    MULDIV_OP = 3'($urandom); A_data = $urandom; B_data = $urandom;
  endtask

  task automatic move_to(input logic [2:0] op, input logic [W-1:0] a);
    issue(op, a, $urandom);
    if (op == 3'd5) model_hi = a;
    if (op == 3'd6) model_lo = a;
  endtask

  // Iterative op with busy/latency checks; optionally injects a start while busy.
  task automatic run_iter(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject, input logic [2:0] inj_op);
    int n;
    bit got;
    sb_q.push_back(ref_model(op, a, b));
    issue(op, a, b);
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else check("busy_during_op", 64'(busy), 64'd1);
      if (inject && n == 5) begin
        MULDIV_OP = inj_op; A_data = $urandom; B_data = $urandom; start = 1'b1;
      end
      if (n == 6) start = 1'b0;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL done_timeout: got no done after %0d cycles, required 34", n);
    end else begin
      check("done_latency", 64'(n), 64'd34);
      check("busy_at_done", 64'(busy), 64'd0);
    end
  endtask

  // Monitor: pops the scoreboard on done; otherwise HI/LO must hold the model value.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (done) begin
          if (sb_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL done_unexpected: got done=1 with nothing outstanding, required 0");
          end else begin
            mon_e = sb_q.pop_front();
`ifdef MULDIV_DIV0_FLAG_EN
            check("div0_at_done", 64'(div0), 64'(mon_e.dz));
            if (mon_e.dz) begin
              mon_e.hi = model_hi;
              mon_e.lo = model_lo;
            end
`endif
            check("hi_result", 64'(HI_data), 64'(mon_e.hi));
            check("lo_result", 64'(LO_data), 64'(mon_e.lo));
            model_hi = mon_e.hi;
            model_lo = mon_e.lo;
          end
        end else begin
          check("hi_stable", 64'(HI_data), 64'(model_hi));
          check("lo_stable", 64'(LO_data), 64'(model_lo));
`ifdef MULDIV_DIV0_FLAG_EN
          check("div0_idle", 64'(div0), 64'd0);
`endif
        end
      end
    end
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    rst_n = 1'b0; start = 1'b0; MULDIV_OP = '0; A_data = '0; B_data = '0;
    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(HI_data), 64'd0);
    check("reset_lo", 64'(LO_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_iter(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0);
    run_iter(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 3'd0);
    run_iter(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'd0);
    run_iter(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd0);
    run_iter(3'd4, 32'd100, 32'd7, 1'b0, 3'd0);
    run_iter(3'd4, 32'd7, 32'd0, 1'b0, 3'd0);
    run_iter(3'd3, 32'hFFFF_FFF9, 32'd0, 1'b0, 3'd0);
    move_to(3'd5, 32'h1234);
    move_to(3'd6, 32'h5678);
    @(negedge clk);
    check("mthi_value", 64'(HI_data), 64'h1234);
    check("mtlo_value", 64'(LO_data), 64'h5678);
    run_iter(3'd2, 32'h0001_0003, 32'h0000_0011, 1'b1, 3'd6);
    run_iter(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'd2);

    // Reset during iteration 10 of a MULTU discards the outstanding result.
    sb_q.push_back(ref_model(3'd2, 32'hDEAD_BEEF, 32'h1357_9BDF));
    issue(3'd2, 32'hDEAD_BEEF, 32'h1357_9BDF);
    repeat (11) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    model_hi = '0;
    model_lo = '0;
    #1;
    check("midop_reset_busy", 64'(busy), 64'd0);
    check("midop_reset_hi", 64'(HI_data), 64'd0);
    check("midop_reset_lo", 64'(LO_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_iter(3'd2, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, 3'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 300));
        default: b = 32'($urandom);
      endcase
      if (op >= 3'd1 && op <= 3'd4)
        run_iter(op, a, b, ($urandom_range(0, 2) == 0), 3'($urandom_range(1, 7)));
      else if (op == 3'd5 || op == 3'd6)
        move_to(op, a);
      else begin
        issue(op, a, b);
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
